// File: rtl/lighthouse_sweep_sequencer.sv
// lighthouse_sweep_sequencer: measures photodiode pulses and times sync-to-laser sweeps
`ifndef PULSE_DURATION_SIZE
`define PULSE_DURATION_SIZE 9
`endif
`ifndef PULSE_TYPE_SIZE_OF
`define PULSE_TYPE_SIZE_OF 3
`endif
`ifndef PULSE_TYPE_X0
`define PULSE_TYPE_X0 4'd0
`define PULSE_TYPE_Y0 4'd1
`define PULSE_TYPE_X1 4'd2
`define PULSE_TYPE_Y1 4'd3
`define PULSE_TYPE_X0_SKIP 4'd4
`define PULSE_TYPE_Y0_SKIP 4'd5
`define PULSE_TYPE_X1_SKIP 4'd6
`define PULSE_TYPE_Y1_SKIP 4'd7
`define PULSE_TYPE_LASER 4'd8
`define PULSE_TYPE_INTERVAL 4'd9
`endif
module lighthouse_sweep_sequencer #(
  parameter int TS_W = 20,
  parameter logic [TS_W-1:0] MAX_SWEEP = TS_W'(400000)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sensor,
  output logic [`PULSE_DURATION_SIZE:0]  dur,
  input  logic [`PULSE_TYPE_SIZE_OF:0]   pulse_type,
  output logic                           sweep_valid,
  output logic [1:0]                     sweep_axis,
  output logic [TS_W-1:0]                sweep_time,
  output logic                           sweep_timeout,
  output logic                           armed
);
  typedef enum logic {IDLE, ARMED} state_t;
  state_t                        r_state, w_next;
  logic [TS_W-1:0]               r_ts, r_rise_ts, r_cls_rise_ts, r_sync_ts, w_elapsed;
  logic [`PULSE_DURATION_SIZE:0] r_hi_count;
  logic                          r_sq, r_cls_pending;
  logic [1:0]                    r_axis_pend;
  logic                          w_rise, w_fall, w_sync, w_laser, w_valid, w_timeout;
  assign w_rise    = sensor & ~r_sq;
  assign w_fall    = ~sensor & r_sq;
  assign w_sync    = r_cls_pending && pulse_type <= `PULSE_TYPE_Y1;
  assign w_laser   = r_cls_pending && pulse_type == `PULSE_TYPE_LASER;
  assign w_elapsed = r_ts - r_sync_ts;
  // a pending classification always wins over the timeout check
  always_comb begin
    w_valid   = r_state == ARMED && w_laser;
    w_timeout = r_state == ARMED && !r_cls_pending && w_elapsed >= MAX_SWEEP;
    w_next    = w_sync ? ARMED : (w_valid || w_timeout) ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ts          <= '0;
      r_sq          <= 1'b0;
      r_rise_ts     <= '0;
      r_cls_rise_ts <= '0;
      r_sync_ts     <= '0;
      r_hi_count    <= '0;
      r_cls_pending <= 1'b0;
      r_axis_pend   <= '0;
      dur           <= '0;
      sweep_valid   <= 1'b0;
      sweep_axis    <= '0;
      sweep_time    <= '0;
      sweep_timeout <= 1'b0;
      armed         <= 1'b0;
    end else begin
      r_ts          <= r_ts + 1'b1;
      r_sq          <= sensor;
      r_state       <= w_next;
      armed         <= w_next == ARMED;
      sweep_valid   <= w_valid;
      sweep_timeout <= w_timeout;
      r_cls_pending <= w_fall;
      if (w_rise) begin
        r_rise_ts  <= r_ts;
        r_hi_count <= 1;
      end else if (sensor && !(&r_hi_count)) begin
        r_hi_count <= r_hi_count + 1'b1;
      end
      // rise_ts may be overwritten by a back-to-back rise, so keep the classified pulse's copy
      if (w_fall) begin
        dur           <= r_hi_count;
        r_cls_rise_ts <= r_rise_ts;
      end
      if (w_sync) begin
        r_sync_ts   <= r_cls_rise_ts;
        r_axis_pend <= pulse_type[1:0];
      end
      if (w_valid) begin
        sweep_time <= r_cls_rise_ts - r_sync_ts;
        sweep_axis <= r_axis_pend;
      end
    end
  end
endmodule

// File: tb/tb_lighthouse_sweep_sequencer.sv
// tb_lighthouse_sweep_sequencer: directed scoreboard bench for the sweep sequencer
`ifndef PULSE_DURATION_SIZE
`define PULSE_DURATION_SIZE 9
`endif
`ifndef PULSE_TYPE_SIZE_OF
`define PULSE_TYPE_SIZE_OF 3
`endif
`ifndef PULSE_TYPE_X0
`define PULSE_TYPE_X0 4'd0
`define PULSE_TYPE_Y0 4'd1
`define PULSE_TYPE_X1 4'd2
`define PULSE_TYPE_Y1 4'd3
`define PULSE_TYPE_X0_SKIP 4'd4
`define PULSE_TYPE_Y0_SKIP 4'd5
`define PULSE_TYPE_X1_SKIP 4'd6
`define PULSE_TYPE_Y1_SKIP 4'd7
`define PULSE_TYPE_LASER 4'd8
`define PULSE_TYPE_INTERVAL 4'd9
`endif
module tb_lighthouse_sweep_sequencer;
  logic clk = 1'b0, rst = 1'b1, sensor = 1'b0;
  logic [`PULSE_TYPE_SIZE_OF:0] pulse_type = `PULSE_TYPE_INTERVAL;
  logic [`PULSE_DURATION_SIZE:0] dur_a, dur_b;
  logic va, vb, toa, tob, arm_a, arm_b;
  logic [1:0] ax_a, ax_b;
  logic [19:0] tm_a;
  logic [11:0] tm_b;
  logic [19:0] tb_ts;
  int errors = 0, checks = 0, nva = 0, nvb = 0;
  typedef struct {bit inst; logic [19:0] t; logic [1:0] ax;} exp_t;
  exp_t q[$];
  lighthouse_sweep_sequencer u_a (
    .clk(clk), .rst(rst), .sensor(sensor), .dur(dur_a), .pulse_type(pulse_type),
    .sweep_valid(va), .sweep_axis(ax_a), .sweep_time(tm_a), .sweep_timeout(toa), .armed(arm_a));
  lighthouse_sweep_sequencer #(.TS_W(12), .MAX_SWEEP(12'd1000)) u_b (
    .clk(clk), .rst(rst), .sensor(sensor), .dur(dur_b), .pulse_type(pulse_type),
    .sweep_valid(vb), .sweep_axis(ax_b), .sweep_time(tm_b), .sweep_timeout(tob), .armed(arm_b));
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) tb_ts <= rst ? 20'd0 : tb_ts + 20'd1;
  always @(posedge clk) begin
    if (va) nva <= nva + 1;
    if (vb) nvb <= nvb + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic at_ts(input logic [19:0] t);
    int n = 0;
    while (tb_ts != t && n < 60000) begin @(negedge clk); n++; end
    if (n >= 60000) check("at_ts_bound", {12'd0, tb_ts}, {12'd0, t});
  endtask
  // recognizer model: class is presented once the pulse has ended and held until the next fall
  task automatic pulse(input logic [19:0] t, input int h, input logic [3:0] cls);
    at_ts(t);
    sensor = 1'b1;
    repeat (h) @(negedge clk);
    sensor = 1'b0;
    pulse_type = cls;
  endtask
  task automatic expect_sweep(input string tag, input bit inst);
    exp_t e;
    int n = 0;
    e = q.pop_front();
    do begin @(negedge clk); n++; end while (!(inst ? vb : va) && n < 8);
    check({tag, "_latency"}, n, 2);
    check({tag, "_axis"}, inst ? ax_b : ax_a, {30'd0, e.ax});
    check({tag, "_time"}, inst ? {8'd0, tm_b} : tm_a, {12'd0, e.t});
    check({tag, "_armed_drop"}, inst ? arm_b : arm_a, 0);
    check({tag, "_no_timeout"}, inst ? tob : toa, 0);
    @(negedge clk);
    check({tag, "_one_cycle"}, inst ? vb : va, 0);
  endtask
  initial begin
    int n0, n;
    repeat (3) @(negedge clk);
    check("rst_dur", dur_a, 0);
    check("rst_valid", va, 0);
    check("rst_axis", ax_a, 0);
    check("rst_time", tm_a, 0);
    check("rst_timeout", toa, 0);
    check("rst_armed", arm_a, 0);
    rst = 1'b0;
    pulse(0, 10, `PULSE_TYPE_Y1);
    repeat (3) @(negedge clk);
    check("y1_armed", arm_a, 1);
    pulse(8000, 10, `PULSE_TYPE_X0_SKIP);
    pulse(16000, 10, `PULSE_TYPE_Y0);
    q.push_back('{1'b0, 20'd4000, 2'd1});
    pulse(20000, 10, `PULSE_TYPE_LASER);
    expect_sweep("skip_rearm", 1'b0);
    pulse(21000, 10, `PULSE_TYPE_X0);
    repeat (3) @(negedge clk);
    check("pre_reset_armed", arm_a, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dur", dur_a, 0);
    check("async_rst_armed", arm_a, 0);
    check("async_rst_axis", ax_a, 0);
    check("async_rst_time", tm_a, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n0 = nva;
    pulse(20, 5, `PULSE_TYPE_LASER);
    repeat (6) @(negedge clk);
    check("laser_after_reset", nva, n0);
    pulse(100, 10, `PULSE_TYPE_X0);
    q.push_back('{1'b0, 20'd5000, 2'd0});
    pulse(5100, 10, `PULSE_TYPE_LASER);
    expect_sweep("basic", 1'b0);
    pulse(6000, 10, `PULSE_TYPE_Y1);
    q.push_back('{1'b0, 20'd11, 2'd3});
    pulse(6011, 4, `PULSE_TYPE_LASER);
    expect_sweep("gap1", 1'b0);
    n0 = nva;
    pulse(7000, 37, `PULSE_TYPE_INTERVAL);
    @(negedge clk);
    check("dur_37", dur_a, 37);
    pulse(8000, (1 << (`PULSE_DURATION_SIZE + 1)) + 10, `PULSE_TYPE_LASER);
    @(negedge clk);
    check("dur_saturate", dur_a, (1 << (`PULSE_DURATION_SIZE + 1)) - 1);
    repeat (4) @(negedge clk);
    check("idle_no_strobe", nva, n0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulse(50, 10, `PULSE_TYPE_X1);
    repeat (3) @(negedge clk);
    check("x1_armed", arm_b, 1);
    pulse(500, 10, `PULSE_TYPE_X0_SKIP);
    n = 0;
    while (!tob && n < 2000) begin @(negedge clk); n++; end
    check("timeout_ts", tb_ts, 1051);
    check("timeout_armed", arm_b, 0);
    check("timeout_no_valid", vb, 0);
    @(negedge clk);
    check("timeout_one_cycle", tob, 0);
    n0 = nvb;
    pulse(1200, 10, `PULSE_TYPE_LASER);
    repeat (4) @(negedge clk);
    check("laser_after_timeout", nvb, n0);
    pulse(3840, 10, `PULSE_TYPE_Y0);
    q.push_back('{1'b1, 20'h200, 2'd1});
    pulse(4352, 10, `PULSE_TYPE_LASER);
    expect_sweep("wrap", 1'b1);
    n0 = nvb;
    pulse(5000, 10, `PULSE_TYPE_INTERVAL);
    repeat (4) @(negedge clk);
    check("interval_no_strobe", nvb, n0);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
